parameter_function_lut: RTL and testbench
=========================================

Name: parameter_function_lut

Overview:
- Clocked, table-driven successor to the combinational PWL-to-parameter mapping blocks.
- Samples one PWL input each clock and maps it through a per-mode piecewise-linear lookup table, with linear interpolation between points.
- Drives a slew-limited real-valued parameter to downstream behavioural models, e.g. gain, bandwidth or offset of an amplifier/filter model.
- Adds what the combinational template lacks: a runtime-loadable table, a mode-switch handshake with settling, and a bounded output step per cycle.

Parameters:
- BW_MODE, 2, bit width of mode select; number of modes NUM_MODE = 2**BW_MODE.
- BW_IDX, 4, bit width of table address; points per mode NUM_PTS = 2**BW_IDX.
- IN_MIN, 0.0, input value mapped to table point 0.
- IN_STEP, 0.1, input spacing between adjacent table points (>0).
- MAX_STEP, 0.05, maximum |change| of out_param per clock (>0).
- SETTLE_CYC, 3, clocks spent in SETTLE after a mode switch (>=1).
- INIT_VAL, 0.0, reset value of out_param and of every table entry.

Ports:
- clk  input  1  sampling clock, rising edge active.
- rstb  input  1  asynchronous active-low reset.
- in1  input  pwl  analog input (`input_pwl); evaluated at each rising clk edge.
- mode  input  BW_MODE  requested mode; captured only on an accepted mode_req.
- mode_req  input  1  mode-change request, level-held until mode_ack.
- mode_ack  output  1  one-cycle pulse when the request is accepted.
- tbl_we  input  1  table write enable.
- tbl_mode  input  BW_MODE  table write mode index.
- tbl_addr  input  BW_IDX  table write point index.
- tbl_data  input  real  table write value.
- out_param  output  real  mapped, slew-limited parameter (`output_real).
- cur_mode  output  BW_MODE  mode in effect.
- settled  output  1  high when out_param equals the current target.
- busy  output  1  high in SWITCH or SETTLE.

Behaviour:
- Reset (rstb low, asynchronous):
  - out_param = INIT_VAL, cur_mode = 0, mode_ack = 0, busy = 0, settled = 0.
  - All table entries = INIT_VAL.
  - FSM = TRACK.
  - Reset mid-switch abandons the switch; no ack is issued.
- Input sampling, per rising clk:
  - x = in1 value at the edge time (PWL eval).
  - u = (x - IN_MIN) / IN_STEP.
  - idx = floor(u) clamped to [0, NUM_PTS-2].
  - frac = u - idx clamped to [0.0, 1.0].
  - Below range gives point 0; above range gives point NUM_PTS-1. No extrapolation.
- Target: tgt = T[cur_mode][idx] + frac * (T[cur_mode][idx+1] - T[cur_mode][idx]).
- Slew, per clock in TRACK and SETTLE:
  - d = tgt - out_param.
  - If |d| <= MAX_STEP: out_param = tgt and settled = 1.
  - Otherwise out_param += sign(d) * MAX_STEP and settled = 0.
  - Latency: out_param updates one clock after the sample. Full convergence takes ceil(|d|/MAX_STEP) clocks.
- Table write:
  - On a clk edge with tbl_we = 1, T[tbl_mode][tbl_addr] = tbl_data.
  - The new value is visible to the target computation on the next edge.
  - A write to cur_mode during tracking is legal and the output slews to the new target.
  - A write in the same cycle as a mode_req accept is honoured.
- FSM TRACK:
  - On mode_req = 1: pulse mode_ack and go to SWITCH.
  - If mode equals cur_mode: ack but stay in TRACK, no settle.
- FSM SWITCH (1 cycle):
  - cur_mode = latched mode; out_param is held; busy = 1.
  - Go to SETTLE.
- FSM SETTLE:
  - Slew runs; a counter counts SETTLE_CYC clocks; busy = 1.
  - Go to TRACK when the count expires AND settled = 1. Otherwise remain in SETTLE until settled.
  - mode_req is ignored (not acked) in SWITCH and SETTLE and stays pending.
- Output events: out_param changes only on clk edges or reset (no intra-cycle events). mode_ack is exactly one cycle wide.

Test Plan:
- Reset/init:
  - Stimulus: assert rstb low mid-cycle; then table mode0 with T[0][k] = k*1.0, MAX_STEP = 100, in1 = 0.35.
  - Required: out_param = 0.0 immediately on reset; after release and one clock, out_param = 3.5 and settled = 1.
- Clamping:
  - Stimulus: in1 = -1.0, then in1 = 5.0 on the same table.
  - Required: out_param = 0.0, then 15.0 (point 15). No extrapolation.
- Slew:
  - Stimulus: MAX_STEP = 0.5; step target from 0.0 to 2.0.
  - Required: out_param = 0.5, 1.0, 1.5, 2.0 on four successive clocks; settled rises on the 4th.
- Mode switch:
  - Stimulus: T[1][k] = -k; raise mode_req with mode = 1 at in1 = 0.2.
  - Required: mode_ack pulses 1 cycle; busy for 1 + max(SETTLE_CYC, slew cycles) clocks; cur_mode = 1; final out_param = -2.0.
- Request during SETTLE:
  - Stimulus: second mode_req (mode = 2) held during SETTLE.
  - Required: no ack until TRACK is re-entered; ack arrives on the first TRACK cycle, then mode 2 takes effect.
- Reset mid-switch:
  - Stimulus: drop rstb during SETTLE.
  - Required: cur_mode = 0, busy = 0, table restored to INIT_VAL, no stray mode_ack.

Source files
------------

// File: rtl/parameter_function_lut_if.sv
// Mode-switch handshake and runtime table-write bus of parameter_function_lut.
interface parameter_function_lut_if #(
   parameter int BW_MODE = 2,
   parameter int BW_IDX  = 4
);
   logic [BW_MODE-1:0] mode;
   logic               mode_req;
   logic               mode_ack;
   logic               tbl_we;
   logic [BW_MODE-1:0] tbl_mode;
   logic [BW_IDX-1:0]  tbl_addr;
   real                tbl_data;

   modport master (output mode, mode_req, tbl_we, tbl_mode, tbl_addr, tbl_data,
                   input  mode_ack);
   modport slave  (input  mode, mode_req, tbl_we, tbl_mode, tbl_addr, tbl_data,
                   output mode_ack);
endinterface

// File: rtl/parameter_function_lut.sv
// Clocked PWL-to-parameter mapper: per-mode lookup table with linear interpolation,
// slew-limited real output and a mode-switch handshake followed by a settling phase.
module parameter_function_lut #(
   parameter int  BW_MODE    = 2,
   parameter int  BW_IDX     = 4,
   parameter real IN_MIN     = 0.0,
   parameter real IN_STEP    = 0.1,
   parameter real MAX_STEP   = 0.05,
   parameter int  SETTLE_CYC = 3,
   parameter real INIT_VAL   = 0.0
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  real                     in1,
   parameter_function_lut_if.slave bus,
   output real                     out_param,
   output logic [BW_MODE-1:0]      cur_mode,
   output logic                    settled,
   output logic                    busy
);
   localparam int NUM_MODE = 2 ** BW_MODE;
   localparam int NUM_PTS  = 2 ** BW_IDX;
   localparam int TBL_SIZE = NUM_MODE * NUM_PTS;
   localparam int CNT_W    = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [BW_IDX-1:0] IDX_TOP = BW_IDX'(NUM_PTS - 2);
   localparam logic [BW_IDX-1:0] IDX_ONE = BW_IDX'(1);

   typedef enum logic [1:0] {
      ST_TRACK  = 2'd0,
      ST_SWITCH = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   real                tbl_r [TBL_SIZE];
   real                out_r;
   real                out_s;
   real                u_s;
   real                fl_s;
   real                frac_raw_s;
   real                frac_s;
   real                lo_s;
   real                hi_s;
   real                tgt_s;
   real                diff_s;
   real                slew_out_s;
   logic               slew_done_s;
   logic [BW_IDX-1:0]  idx_s;
   logic [BW_MODE-1:0] cur_mode_r;
   logic [BW_MODE-1:0] cur_mode_s;
   logic [BW_MODE-1:0] pend_mode_r;
   logic [BW_MODE-1:0] pend_mode_s;
   logic               ack_r;
   logic               ack_s;
   logic               settled_r;
   logic               settled_s;
   logic               busy_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_s;
   state_t             state_r;
   state_t             state_s;

   // Locate the table segment of the sampled input and interpolate the target
   always_comb begin
      u_s  = (in1 - IN_MIN) / IN_STEP;
      fl_s = $floor(u_s);
      if (fl_s <= 0.0) begin
         idx_s = '0;
      end else if (fl_s >= real'(NUM_PTS - 2)) begin
         idx_s = IDX_TOP;
      end else begin
         idx_s = BW_IDX'($rtoi(fl_s));
      end
      // Clamping frac to [0,1] pins out-of-range inputs to the end points
      frac_raw_s = u_s - real'(idx_s);
      if (frac_raw_s < 0.0) begin
         frac_s = 0.0;
      end else if (frac_raw_s > 1.0) begin
         frac_s = 1.0;
      end else begin
         frac_s = frac_raw_s;
      end
      lo_s  = tbl_r[{cur_mode_r, idx_s}];
      hi_s  = tbl_r[{cur_mode_r, idx_s + IDX_ONE}];
      tgt_s = lo_s + frac_s * (hi_s - lo_s);
   end

   // Bounded step of the output toward the target
   always_comb begin
      diff_s = tgt_s - out_r;
      if (diff_s > MAX_STEP) begin
         slew_out_s  = out_r + MAX_STEP;
         slew_done_s = 1'b0;
      end else if (diff_s < -MAX_STEP) begin
         slew_out_s  = out_r - MAX_STEP;
         slew_done_s = 1'b0;
      end else begin
         slew_out_s  = tgt_s;
         slew_done_s = 1'b1;
      end
   end

   // Mode FSM next state, handshake and output selection
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      pend_mode_s = pend_mode_r;
      cur_mode_s  = cur_mode_r;
      out_s       = out_r;
      settled_s   = settled_r;
      ack_s       = 1'b0;
      case (state_r)
         ST_TRACK: begin
            out_s     = slew_out_s;
            settled_s = slew_done_s;
            // The ack_r guard keeps a requester that drops late from being acked twice
            if (bus.mode_req && !ack_r) begin
               ack_s = 1'b1;
               if (bus.mode != cur_mode_r) begin
                  pend_mode_s = bus.mode;
                  state_s     = ST_SWITCH;
               end else begin
                  state_s = ST_TRACK;
               end
            end else begin
               state_s = ST_TRACK;
            end
         end
         ST_SWITCH: begin
            cur_mode_s = pend_mode_r;
            settled_s  = 1'b0;
            cnt_s      = '0;
            state_s    = ST_SETTLE;
         end
         ST_SETTLE: begin
            out_s     = slew_out_s;
            settled_s = slew_done_s;
            if (cnt_r < CNT_MAX) begin
               cnt_s = cnt_r + CNT_ONE;
            end else begin
               cnt_s = cnt_r;
            end
            if ((cnt_s == CNT_MAX) && slew_done_s) begin
               state_s = ST_TRACK;
            end else begin
               state_s = ST_SETTLE;
            end
         end
         default: begin
            state_s = ST_TRACK;
         end
      endcase
   end

   // FSM, handshake and output registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r     <= ST_TRACK;
         cnt_r       <= '0;
         pend_mode_r <= '0;
         cur_mode_r  <= '0;
         out_r       <= INIT_VAL;
         settled_r   <= 1'b0;
         ack_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         pend_mode_r <= pend_mode_s;
         cur_mode_r  <= cur_mode_s;
         out_r       <= out_s;
         settled_r   <= settled_s;
         ack_r       <= ack_s;
         busy_r      <= (state_s != ST_TRACK);
      end
   end

   // Runtime-loadable table; a write is seen by the target one edge later
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < TBL_SIZE; i++) begin
            tbl_r[i] <= INIT_VAL;
         end
      end else begin
         if (bus.tbl_we) begin
            tbl_r[{bus.tbl_mode, bus.tbl_addr}] <= bus.tbl_data;
         end
      end
   end

   assign out_param    = out_r;
   assign cur_mode     = cur_mode_r;
   assign settled      = settled_r;
   assign busy         = busy_r;
   assign bus.mode_ack = ack_r;
endmodule

// File: tb/tb_parameter_function_lut.sv
// Self-checking bench for parameter_function_lut against a cycle-level behavioural model.
module tb_parameter_function_lut;
   localparam int  BW_MODE    = 2;
   localparam int  BW_IDX     = 4;
   localparam int  NUM_MODE   = 4;
   localparam int  NUM_PTS    = 16;
   localparam int  SETTLE_CYC = 3;
   localparam real IN_MIN     = 0.0;
   localparam real IN_STEP    = 0.1;
   localparam real MAX_STEP   = 0.5;
   localparam real INIT_VAL   = 0.0;
   localparam real TOL        = 1.0e-6;

   logic       clk  = 1'b0;
   logic       rstb = 1'b0;
   real        in1  = 0.0;
   real        out_param;
   logic [1:0] cur_mode;
   logic       settled;
   logic       busy;
   int         n_tests = 0;
   int         n_fail  = 0;

   // reference model state
   real m_tbl [NUM_MODE][NUM_PTS];
   real m_out;
   bit  m_settled, m_ack, m_busy;
   int  m_cur, m_pend, m_phase, m_n;   // m_phase: 0 tracking, 1 switching, 2 settling

   parameter_function_lut_if #(.BW_MODE(BW_MODE), .BW_IDX(BW_IDX)) bus ();

   parameter_function_lut #(
      .BW_MODE(BW_MODE), .BW_IDX(BW_IDX), .IN_MIN(IN_MIN), .IN_STEP(IN_STEP),
      .MAX_STEP(MAX_STEP), .SETTLE_CYC(SETTLE_CYC), .INIT_VAL(INIT_VAL)
   ) dut (
      .clk(clk), .rstb(rstb), .in1(in1), .bus(bus), .out_param(out_param),
      .cur_mode(cur_mode), .settled(settled), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic real ref_map(input int md, input real x);
      real t;
      if (x <= IN_MIN) return m_tbl[md][0];
      if (x >= IN_MIN + (NUM_PTS - 1) * IN_STEP) return m_tbl[md][NUM_PTS-1];
      for (int k = 0; k < NUM_PTS - 1; k++) begin
         if (x < IN_MIN + (k + 1) * IN_STEP) begin
            t = (x - (IN_MIN + k * IN_STEP)) / IN_STEP;
            return m_tbl[md][k] * (1.0 - t) + m_tbl[md][k+1] * t;
         end
      end
      return m_tbl[md][NUM_PTS-1];
   endfunction

   function automatic real rnd_val();
      return real'(int'($urandom_range(0, 8000)) - 4000) / 1000.0;
   endfunction

   task automatic model_reset();
      for (int a = 0; a < NUM_MODE; a++)
         for (int b = 0; b < NUM_PTS; b++) m_tbl[a][b] = INIT_VAL;
      m_out = INIT_VAL; m_settled = 0; m_ack = 0; m_busy = 0;
      m_cur = 0; m_pend = 0; m_phase = 0; m_n = 0;
   endtask

   // one clock: capture inputs, advance the model at the edge, settle #1 after it
   task automatic tick();
      real x, wd, tgt, d;
      bit  req, we;
      int  md, wm, wa;
      x = in1; req = bus.mode_req; md = int'(bus.mode);
      we = bus.tbl_we; wm = int'(bus.tbl_mode); wa = int'(bus.tbl_addr); wd = bus.tbl_data;
      @(posedge clk);
      if (rstb) begin
         tgt = ref_map(m_cur, x);
         if (m_phase == 1) begin
            m_cur = m_pend; m_settled = 0; m_phase = 2; m_n = 0; m_ack = 0;
         end else begin
            d = tgt - m_out;
            if (d > MAX_STEP) begin m_out = m_out + MAX_STEP; m_settled = 0; end
            else if (d < -MAX_STEP) begin m_out = m_out - MAX_STEP; m_settled = 0; end
            else begin m_out = tgt; m_settled = 1; end
            if (m_phase == 0) begin
               if (req && !m_ack) begin
                  m_ack = 1;
                  if (md != m_cur) begin m_pend = md; m_phase = 1; end
               end else m_ack = 0;
            end else begin
               m_ack = 0; m_n++;
               if (m_n >= SETTLE_CYC && m_settled) m_phase = 0;
            end
         end
         if (we) m_tbl[wm][wa] = wd;
         m_busy = (m_phase != 0);
      end
      #1;
   endtask

   task automatic write_tbl(input int md, input int addr, input real val);
      bus.tbl_we = 1'b1; bus.tbl_mode = 2'(md); bus.tbl_addr = 4'(addr); bus.tbl_data = val;
      tick();
      bus.tbl_we = 1'b0;
   endtask

   task automatic test_reset();
      #13;
      n_tests++; if ((out_param - INIT_VAL) > TOL || (INIT_VAL - out_param) > TOL) begin n_fail++; $display("FAIL reset_out: got %f expected %f", out_param, INIT_VAL); end
      n_tests++; if (cur_mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", cur_mode); end
      n_tests++; if (busy !== 1'b0 || bus.mode_ack !== 1'b0) begin n_fail++; $display("FAIL reset_busy_ack: got %b%b expected 00", busy, bus.mode_ack); end
      n_tests++; if (settled !== 1'b0) begin n_fail++; $display("FAIL reset_settled: got %b expected 0", settled); end
      #4 rstb = 1'b1;
      in1 = 0.35;
      for (int k = 0; k < NUM_PTS; k++) write_tbl(0, k, real'(k));
      #3 rstb = 1'b0;
      #1;
      n_tests++; if ((out_param - INIT_VAL) > TOL || (INIT_VAL - out_param) > TOL) begin n_fail++; $display("FAIL async_reset_out: got %f expected %f", out_param, INIT_VAL); end
      n_tests++; if (settled !== 1'b0) begin n_fail++; $display("FAIL async_reset_settled: got %b expected 0", settled); end
      model_reset();
      #1 rstb = 1'b1;
      for (int k = 0; k < NUM_PTS; k++) write_tbl(0, k, real'(k));
      repeat (12) tick();
      n_tests++; if ((out_param - 3.5) > TOL || (3.5 - out_param) > TOL) begin n_fail++; $display("FAIL interp_035: got %f expected 3.5", out_param); end
      n_tests++; if (settled !== 1'b1) begin n_fail++; $display("FAIL interp_settled: got %b expected 1", settled); end
   endtask

   task automatic test_clamp();
      in1 = -1.0;
      repeat (10) tick();
      n_tests++; if ((out_param - 0.0) > TOL || (0.0 - out_param) > TOL) begin n_fail++; $display("FAIL clamp_low: got %f expected 0.0", out_param); end
      in1 = 5.0;
      repeat (32) tick();
      n_tests++; if ((out_param - 15.0) > TOL || (15.0 - out_param) > TOL) begin n_fail++; $display("FAIL clamp_high: got %f expected 15.0", out_param); end
      n_tests++; if (settled !== 1'b1) begin n_fail++; $display("FAIL clamp_settled: got %b expected 1", settled); end
   endtask

   task automatic test_slew();
      real exp_v;
      in1 = 0.0;
      repeat (32) tick();
      n_tests++; if ((out_param - 0.0) > TOL || (0.0 - out_param) > TOL) begin n_fail++; $display("FAIL slew_start: got %f expected 0.0", out_param); end
      in1 = 0.2;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_v = 0.5 * (i + 1);
         n_tests++; if ((out_param - exp_v) > TOL || (exp_v - out_param) > TOL) begin n_fail++; $display("FAIL slew_step%0d: got %f expected %f", i, out_param, exp_v); end
         n_tests++; if (settled !== (i == 3)) begin n_fail++; $display("FAIL slew_settled%0d: got %b expected %b", i, settled, (i == 3)); end
      end
   endtask

   task automatic test_mode_switch();
      int ack_cnt = 0, busy_cnt = 0;
      bit done = 0;
      for (int k = 0; k < NUM_PTS; k++) write_tbl(1, k, -real'(k));
      bus.mode = 2'd1; bus.mode_req = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (bus.mode_ack === 1'b1) begin ack_cnt++; bus.mode_req = 1'b0; end
         if (busy === 1'b1) busy_cnt++;
         else if (busy_cnt > 0) done = 1;
      end
      bus.mode_req = 1'b0;
      n_tests++; if (!done) begin n_fail++; $display("FAIL switch_timeout: got busy %b expected 0 within 40 cycles", busy); end
      n_tests++; if (ack_cnt != 1) begin n_fail++; $display("FAIL switch_ack_width: got %0d expected 1", ack_cnt); end
      // one SWITCH cycle plus max(SETTLE_CYC, 8 slew cycles for 2.0 -> -2.0)
      n_tests++; if (busy_cnt != 9) begin n_fail++; $display("FAIL switch_busy_len: got %0d expected 9", busy_cnt); end
      n_tests++; if (cur_mode !== 2'd1) begin n_fail++; $display("FAIL switch_mode: got %0d expected 1", cur_mode); end
      n_tests++; if ((out_param + 2.0) > TOL || (-2.0 - out_param) > TOL) begin n_fail++; $display("FAIL switch_out: got %f expected -2.0", out_param); end
   endtask

   task automatic test_req_during_settle();
      int  ack_cnt = 0, since = 0;
      bit  sent = 0, done = 0, prev_busy;
      for (int k = 0; k < NUM_PTS; k++) write_tbl(2, k, rnd_val());
      for (int k = 0; k < NUM_PTS; k++) write_tbl(3, k, 0.25 * k);
      in1 = 0.537;
      prev_busy = busy;
      bus.mode = 2'd3; bus.mode_req = 1'b1;
      for (int i = 0; i < 80 && !done; i++) begin
         tick();
         n_tests++; if (bus.mode_ack !== m_ack) begin n_fail++; $display("FAIL settle_req_ack: got %b expected %b", bus.mode_ack, m_ack); end
         if (bus.mode_ack === 1'b1) begin
            ack_cnt++;
            bus.mode_req = 1'b0;
            n_tests++; if (prev_busy !== 1'b0) begin n_fail++; $display("FAIL settle_req_ack_in_track: got prior busy %b expected 0", prev_busy); end
         end
         if (ack_cnt == 1) since++;
         if (since == 2 && !sent) begin bus.mode = 2'd2; bus.mode_req = 1'b1; sent = 1; end
         if (ack_cnt == 2 && busy === 1'b0) done = 1;
         prev_busy = busy;
      end
      bus.mode_req = 1'b0;
      n_tests++; if (!done) begin n_fail++; $display("FAIL settle_req_timeout: got acks %0d expected 2 within 80 cycles", ack_cnt); end
      n_tests++; if (cur_mode !== 2'd2) begin n_fail++; $display("FAIL settle_req_mode: got %0d expected 2", cur_mode); end
      n_tests++; if ((out_param - m_out) > TOL || (m_out - out_param) > TOL) begin n_fail++; $display("FAIL settle_req_out: got %f expected %f", out_param, m_out); end
   endtask

   task automatic test_same_mode();
      bus.mode = cur_mode; bus.mode_req = 1'b1;
      tick();
      n_tests++; if (bus.mode_ack !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL same_mode_ack: got ack %b busy %b expected 1 0", bus.mode_ack, busy); end
      bus.mode_req = 1'b0;
      tick();
      n_tests++; if (bus.mode_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL same_mode_after: got ack %b busy %b expected 0 0", bus.mode_ack, busy); end
      n_tests++; if (cur_mode !== 2'(m_cur)) begin n_fail++; $display("FAIL same_mode_mode: got %0d expected %0d", cur_mode, m_cur); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         in1 = real'($urandom_range(0, 1800)) * 0.001 - 0.15 + 0.000137;
         bus.tbl_we   = ($urandom_range(0, 9) < 4);
         bus.tbl_mode = ($urandom_range(0, 1) == 0) ? cur_mode : 2'($urandom_range(0, 3));
         bus.tbl_addr = 4'($urandom_range(0, 15));
         bus.tbl_data = rnd_val();
         tick();
         n_tests++; if ((out_param - m_out) > TOL || (m_out - out_param) > TOL) begin n_fail++; $display("FAIL rand_out cyc %0d: got %f expected %f", i, out_param, m_out); end
         n_tests++; if (settled !== m_settled) begin n_fail++; $display("FAIL rand_settled cyc %0d: got %b expected %b", i, settled, m_settled); end
         n_tests++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy cyc %0d: got %b expected %b", i, busy, m_busy); end
         n_tests++; if (bus.mode_ack !== m_ack) begin n_fail++; $display("FAIL rand_ack cyc %0d: got %b expected %b", i, bus.mode_ack, m_ack); end
         n_tests++; if (cur_mode !== 2'(m_cur)) begin n_fail++; $display("FAIL rand_mode cyc %0d: got %0d expected %0d", i, cur_mode, m_cur); end
         if (bus.mode_ack === 1'b1) bus.mode_req = 1'b0;
         else if (!bus.mode_req && $urandom_range(0, 15) == 0) begin
            bus.mode = 2'($urandom_range(0, 3)); bus.mode_req = 1'b1;
         end
      end
      bus.tbl_we = 1'b0; bus.mode_req = 1'b0;
      for (int i = 0; i < 60 && (m_busy || m_ack); i++) tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_drain: got busy %b expected 0", busy); end
   endtask

   task automatic test_reset_mid_switch();
      bit got_ack = 0;
      bus.mode = (m_cur == 1) ? 2'd2 : 2'd1; bus.mode_req = 1'b1;
      for (int i = 0; i < 10 && !got_ack; i++) begin
         tick();
         if (bus.mode_ack === 1'b1) got_ack = 1;
      end
      bus.mode_req = 1'b0;
      n_tests++; if (!got_ack) begin n_fail++; $display("FAIL midrst_ack_timeout: got ack 0 expected 1 within 10 cycles"); end
      tick(); tick();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_in_settle: got busy %b expected 1", busy); end
      #3 rstb = 1'b0;
      #1;
      n_tests++; if (cur_mode !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got mode %0d busy %b expected 0 0", cur_mode, busy); end
      n_tests++; if (bus.mode_ack !== 1'b0 || settled !== 1'b0) begin n_fail++; $display("FAIL midrst_ack: got ack %b settled %b expected 0 0", bus.mode_ack, settled); end
      n_tests++; if ((out_param - INIT_VAL) > TOL || (INIT_VAL - out_param) > TOL) begin n_fail++; $display("FAIL midrst_out: got %f expected %f", out_param, INIT_VAL); end
      model_reset();
      #1 rstb = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in1 = real'($urandom_range(0, 1600)) * 0.001;
         tick();
         n_tests++; if (bus.mode_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_stray_ack cyc %0d: got 1 expected 0", i); end
         n_tests++; if ((out_param - INIT_VAL) > TOL || (INIT_VAL - out_param) > TOL) begin n_fail++; $display("FAIL midrst_tbl0 cyc %0d: got %f expected %f", i, out_param, INIT_VAL); end
      end
      bus.mode = 2'd3; bus.mode_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.mode_ack === 1'b1) bus.mode_req = 1'b0;
      end
      bus.mode_req = 1'b0;
      n_tests++; if (cur_mode !== 2'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_mode3: got mode %0d busy %b expected 3 0", cur_mode, busy); end
      n_tests++; if ((out_param - INIT_VAL) > TOL || (INIT_VAL - out_param) > TOL) begin n_fail++; $display("FAIL midrst_tbl3: got %f expected %f", out_param, INIT_VAL); end
   endtask

   initial begin
      bus.mode = 2'd0; bus.mode_req = 1'b0; bus.tbl_we = 1'b0;
      bus.tbl_mode = 2'd0; bus.tbl_addr = 4'd0; bus.tbl_data = 0.0;
      model_reset();
      test_reset();
      test_clamp();
      test_slew();
      test_mode_switch();
      test_req_during_settle();
      test_same_mode();
      test_back_to_back();
      test_reset_mid_switch();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
